// File: rtl/cv32e40s_pkg.sv
// rtl/cv32e40s_pkg.sv - shared types and helpers for the fetch transaction controller
//
// Contents:
//   fetch_txn_state_e   : controller FSM states (IDLE, WAIT_GNT)
//   FETCH_TXN_CNT_W     : width of the outstanding / drop counters
//   fetch_txn_cnt_t     : counter value type
//   fetch_txn_cnt_step  : saturating +1/-1 step used by both counters and the kill reload

package cv32e40s_pkg;

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        WAIT_GNT = 1'b1
    } fetch_txn_state_e;

    localparam int unsigned FETCH_TXN_CNT_W = 3;

    typedef logic [FETCH_TXN_CNT_W-1:0] fetch_txn_cnt_t;

    // Simultaneous inc and dec cancel; the result never wraps at either end.
    function automatic fetch_txn_cnt_t fetch_txn_cnt_step(
        input fetch_txn_cnt_t v,
        input logic           inc,
        input logic           dec
    );
        fetch_txn_cnt_t r;
        r = v;
        if (inc && !dec && (v != '1)) begin
            r = v + fetch_txn_cnt_t'(1);
        end else if (dec && !inc && (v != '0)) begin
            r = v - fetch_txn_cnt_t'(1);
        end
        return r;
    endfunction

endpackage

// File: rtl/cv32e40s_fetch_txn_counter.sv
// rtl/cv32e40s_fetch_txn_counter.sv - saturating up/down counter with parallel load
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   inc, dec   : step up / step down (both together hold the value)
//   load       : load load_val instead of stepping (takes priority)
//   load_val   : value for load
//   cnt        : current count

module cv32e40s_fetch_txn_counter
    import cv32e40s_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    input  logic           inc,
    input  logic           dec,
    input  logic           load,
    input  fetch_txn_cnt_t load_val,
    output fetch_txn_cnt_t cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else begin
            cnt <= fetch_txn_cnt_step(cnt, inc, dec);
        end
    end

endmodule

// File: rtl/cv32e40s_fetch_txn_ctrl.sv
// rtl/cv32e40s_fetch_txn_ctrl.sv - prefetch-to-OBI instruction fetch transaction controller
//
// Sits between the prefetcher transaction interface and the instruction OBI bus.
// Holds an ungranted request stable, limits granted-but-unanswered transactions
// to MAX_OUTSTANDING, and after a kill silently drops responses that belong to
// transactions issued before the kill.
//
// Optional feature macro: CV32E40S_FETCH_ERR_STICKY_EN
//   defined   : a forwarded error response blocks new requests until kill_i
//   undefined : errors are only forwarded
//
// Ports:
//   clk, rst_n                     : clock, asynchronous active-low reset
//   kill_i                         : branch/flush, invalidates all earlier transactions
//   trans_valid_i/ready_o/addr_i   : prefetcher request handshake and address
//   obi_req_o/gnt_i/addr_o         : OBI address phase
//   obi_rvalid_i/rdata_i/err_i     : OBI response phase
//   resp_valid_o/rdata_o/err_o     : forwarded (non-dropped) response
//   outstanding_o                  : granted-unanswered transaction count
//   one_txn_pend_n                 : low when exactly one transaction is outstanding
//   busy_o                         : transactions outstanding or a request waiting for grant

module cv32e40s_fetch_txn_ctrl
    import cv32e40s_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        kill_i,
    input  logic        trans_valid_i,
    output logic        trans_ready_o,
    input  logic [31:0] trans_addr_i,
    output logic        obi_req_o,
    input  logic        obi_gnt_i,
    output logic [31:0] obi_addr_o,
    input  logic        obi_rvalid_i,
    input  logic [31:0] obi_rdata_i,
    input  logic        obi_err_i,
    output logic        resp_valid_o,
    output logic [31:0] resp_rdata_o,
    output logic        resp_err_o,
    output logic [2:0]  outstanding_o,
    output logic        one_txn_pend_n,
    output logic        busy_o
);

    localparam fetch_txn_cnt_t MAX_CNT = fetch_txn_cnt_t'(MAX_OUTSTANDING);

    fetch_txn_state_e state;
    logic [31:0]      held_addr;
    logic             held_killed;
    fetch_txn_cnt_t   cnt;
    fetch_txn_cnt_t   drop_cnt;
    fetch_txn_cnt_t   drop_load_val;
    logic             full;
    logic             grant;
    logic             err_block;

    // A response arriving in the same cycle frees a slot, so it does not block.
    assign full  = (cnt == MAX_CNT) && !obi_rvalid_i;
    assign grant = obi_req_o && obi_gnt_i;

    always_comb begin
        trans_ready_o = 1'b0;
        obi_req_o     = 1'b0;
        obi_addr_o    = trans_addr_i;
        case (state)
            IDLE: begin
                // No handshakes are offered while the block is held in reset.
                trans_ready_o = rst_n && !full && !kill_i && !err_block;
                obi_req_o     = trans_valid_i && trans_ready_o;
                obi_addr_o    = trans_addr_i;
            end
            WAIT_GNT: begin
                // OBI forbids withdrawing or changing a pending request.
                obi_req_o  = 1'b1;
                obi_addr_o = held_addr;
            end
            default: begin
                trans_ready_o = 1'b0;
                obi_req_o     = 1'b0;
                obi_addr_o    = trans_addr_i;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            held_addr   <= '0;
            held_killed <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (obi_req_o && !obi_gnt_i) begin
                        state     <= WAIT_GNT;
                        held_addr <= trans_addr_i;
                    end
                end
                WAIT_GNT: begin
                    if (obi_gnt_i) begin
                        state       <= IDLE;
                        held_killed <= 1'b0;
                    end else if (kill_i) begin
                        // Pending request predates the kill; its response must be
                        // dropped once it is finally granted.
                        held_killed <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    cv32e40s_fetch_txn_counter u_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .inc      (grant),
        .dec      (obi_rvalid_i),
        .load     (1'b0),
        .load_val ('0),
        .cnt      (cnt)
    );

    // On kill every transaction still outstanding after this cycle is old,
    // including one granted in the kill cycle itself, so reload from cnt's next value.
    assign drop_load_val = fetch_txn_cnt_step(cnt, grant, obi_rvalid_i);

    cv32e40s_fetch_txn_counter u_drop_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .inc      (grant && held_killed),
        .dec      (obi_rvalid_i && (drop_cnt != '0)),
        .load     (kill_i),
        .load_val (drop_load_val),
        .cnt      (drop_cnt)
    );

    assign resp_valid_o = obi_rvalid_i && (drop_cnt == '0);
    assign resp_rdata_o = obi_rdata_i;
    assign resp_err_o   = obi_err_i;

`ifdef CV32E40S_FETCH_ERR_STICKY_EN
    // Stop fetching past a bus error until the core redirects.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_block <= 1'b0;
        end else if (kill_i) begin
            err_block <= 1'b0;
        end else if (resp_valid_o && obi_err_i) begin
            err_block <= 1'b1;
        end
    end
`else
    assign err_block = 1'b0;
`endif

    assign outstanding_o  = cnt;
    assign one_txn_pend_n = (cnt != fetch_txn_cnt_t'(1));
    assign busy_o         = (cnt != '0) || (state == WAIT_GNT);

    // A response with nothing outstanding is an OBI protocol violation.
    a_no_rvalid_when_idle: assert property (
        @(posedge clk) disable iff (!rst_n) obi_rvalid_i |-> (cnt != '0)
    );

endmodule

// File: tb/tb_cv32e40s_fetch_txn_ctrl.sv
// tb/tb_cv32e40s_fetch_txn_ctrl.sv - table-driven bench for cv32e40s_fetch_txn_ctrl

module tb_cv32e40s_fetch_txn_ctrl;

`ifdef CV32E40S_FETCH_ERR_STICKY_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        kill_i = 1'b0;
    logic        trans_valid_i = 1'b0;
    logic        trans_ready_o;
    logic [31:0] trans_addr_i = '0;
    logic        obi_req_o;
    logic        obi_gnt_i = 1'b0;
    logic [31:0] obi_addr_o;
    logic        obi_rvalid_i = 1'b0;
    logic [31:0] obi_rdata_i = '0;
    logic        obi_err_i = 1'b0;
    logic        resp_valid_o;
    logic [31:0] resp_rdata_o;
    logic        resp_err_o;
    logic [2:0]  outstanding_o;
    logic        one_txn_pend_n;
    logic        busy_o;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    cv32e40s_fetch_txn_ctrl #(.MAX_OUTSTANDING(2)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .kill_i         (kill_i),
        .trans_valid_i  (trans_valid_i),
        .trans_ready_o  (trans_ready_o),
        .trans_addr_i   (trans_addr_i),
        .obi_req_o      (obi_req_o),
        .obi_gnt_i      (obi_gnt_i),
        .obi_addr_o     (obi_addr_o),
        .obi_rvalid_i   (obi_rvalid_i),
        .obi_rdata_i    (obi_rdata_i),
        .obi_err_i      (obi_err_i),
        .resp_valid_o   (resp_valid_o),
        .resp_rdata_o   (resp_rdata_o),
        .resp_err_o     (resp_err_o),
        .outstanding_o  (outstanding_o),
        .one_txn_pend_n (one_txn_pend_n),
        .busy_o         (busy_o)
    );

    typedef struct {
        logic        kill;
        logic        tv;
        logic [31:0] ta;
        logic        gnt;
        logic        rv;
        logic [31:0] rd;
        logic        err;
        logic        rdy;
        logic        req;
        logic [31:0] addr;
        logic        rvo;
        logic [2:0]  outs;
        logic        pend_n;
        logic        busy;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic kill, input logic tv, input logic [31:0] ta,
                       input logic gnt, input logic rv, input logic [31:0] rd, input logic err,
                       input logic rdy, input logic req, input logic [31:0] addr,
                       input logic rvo, input logic [2:0] outs, input logic pend_n,
                       input logic busy);
        vec_t v;
        v.kill = kill; v.tv = tv; v.ta = ta; v.gnt = gnt; v.rv = rv; v.rd = rd; v.err = err;
        v.rdy = rdy; v.req = req; v.addr = addr; v.rvo = rvo; v.outs = outs;
        v.pend_n = pend_n; v.busy = busy;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        kill_i = 1'b0; trans_valid_i = 1'b0; trans_addr_i = '0; obi_gnt_i = 1'b0;
        obi_rvalid_i = 1'b0; obi_rdata_i = '0; obi_err_i = 1'b0;
    endtask

    initial begin
        //  kill tv ta          gnt rv rd            err | rdy req addr        rvo out pn busy
        // single request, response two cycles after grant
        add(0, 1, 32'h100, 1, 0, 32'h0,        0,   1, 1, 32'h100, 0, 3'd0, 1, 0);
        add(0, 0, 32'h0,   0, 0, 32'h0,        0,   1, 0, 32'h0,   0, 3'd1, 0, 1);
        add(0, 0, 32'h0,   0, 1, 32'hA5A5A5A5, 0,   1, 0, 32'h0,   1, 3'd1, 0, 1);
        add(0, 0, 32'h0,   0, 0, 32'h0,        0,   1, 0, 32'h0,   0, 3'd0, 1, 0);
        // grant withheld three cycles while the prefetcher address moves
        add(0, 1, 32'h200, 0, 0, 32'h0,        0,   1, 1, 32'h200, 0, 3'd0, 1, 0);
        add(0, 1, 32'h300, 0, 0, 32'h0,        0,   0, 1, 32'h200, 0, 3'd0, 1, 1);
        add(0, 1, 32'h300, 0, 0, 32'h0,        0,   0, 1, 32'h200, 0, 3'd0, 1, 1);
        add(0, 1, 32'h300, 1, 0, 32'h0,        0,   0, 1, 32'h200, 0, 3'd0, 1, 1);
        add(0, 1, 32'h300, 1, 0, 32'h0,        0,   1, 1, 32'h300, 0, 3'd1, 0, 1);
        add(0, 0, 32'h0,   0, 1, 32'h11111111, 0,   1, 0, 32'h0,   1, 3'd2, 1, 1);
        add(0, 0, 32'h0,   0, 1, 32'h22222222, 0,   1, 0, 32'h0,   1, 3'd1, 0, 1);
        // outstanding limit of two
        add(0, 1, 32'h500, 1, 0, 32'h0,        0,   1, 1, 32'h500, 0, 3'd0, 1, 0);
        add(0, 1, 32'h504, 1, 0, 32'h0,        0,   1, 1, 32'h504, 0, 3'd1, 0, 1);
        add(0, 1, 32'h508, 1, 0, 32'h0,        0,   0, 0, 32'h508, 0, 3'd2, 1, 1);
        add(0, 1, 32'h508, 1, 1, 32'h33333333, 0,   1, 1, 32'h508, 1, 3'd2, 1, 1);
        // kill with two outstanding, then 0x400 / 0x404
        add(1, 0, 32'h0,   0, 0, 32'h0,        0,   0, 0, 32'h0,   0, 3'd2, 1, 1);
        add(0, 1, 32'h400, 1, 1, 32'h44444444, 0,   1, 1, 32'h400, 0, 3'd2, 1, 1);
        add(0, 1, 32'h404, 1, 1, 32'h55555555, 0,   1, 1, 32'h404, 0, 3'd2, 1, 1);
        add(0, 0, 32'h0,   0, 1, 32'h66666666, 0,   1, 0, 32'h0,   1, 3'd2, 1, 1);
        add(0, 0, 32'h0,   0, 1, 32'h77777777, 0,   1, 0, 32'h0,   1, 3'd1, 0, 1);
        // kill while waiting for grant
        add(0, 1, 32'h600, 0, 0, 32'h0,        0,   1, 1, 32'h600, 0, 3'd0, 1, 0);
        add(1, 0, 32'h0,   0, 0, 32'h0,        0,   0, 1, 32'h600, 0, 3'd0, 1, 1);
        add(0, 0, 32'h0,   0, 0, 32'h0,        0,   0, 1, 32'h600, 0, 3'd0, 1, 1);
        add(0, 0, 32'h0,   1, 0, 32'h0,        0,   0, 1, 32'h600, 0, 3'd0, 1, 1);
        add(0, 0, 32'h0,   0, 1, 32'h88888888, 0,   1, 0, 32'h0,   0, 3'd1, 0, 1);
        add(0, 0, 32'h0,   0, 0, 32'h0,        0,   1, 0, 32'h0,   0, 3'd0, 1, 0);
        // error response: forwarded; blocks only in the sticky build
        add(0, 1, 32'h700, 1, 0, 32'h0,        0,   1, 1, 32'h700, 0, 3'd0, 1, 0);
        add(0, 0, 32'h0,   0, 1, 32'hDEADBEEF, 1,   1, 0, 32'h0,   1, 3'd1, 0, 1);
        add(0, 0, 32'h0,   0, 0, 32'h0,        0,   !STICKY, 0, 32'h0, 0, 3'd0, 1, 0);
        add(1, 0, 32'h0,   0, 0, 32'h0,        0,   0, 0, 32'h0,   0, 3'd0, 1, 0);
        add(0, 0, 32'h0,   0, 0, 32'h0,        0,   1, 0, 32'h0,   0, 3'd0, 1, 0);
        // kill in the same cycle as the waiting request's grant
        add(0, 1, 32'h800, 0, 0, 32'h0,        0,   1, 1, 32'h800, 0, 3'd0, 1, 0);
        add(1, 0, 32'h0,   1, 0, 32'h0,        0,   0, 1, 32'h800, 0, 3'd0, 1, 1);
        add(0, 0, 32'h0,   0, 1, 32'h99999999, 0,   1, 0, 32'h0,   0, 3'd1, 0, 1);
        add(0, 0, 32'h0,   0, 0, 32'h0,        0,   1, 0, 32'h0,   0, 3'd0, 1, 0);

        // reset state
        idle_inputs();
        #3;
        chk("rst.ready",  {31'b0, trans_ready_o},  32'd0);
        chk("rst.req",    {31'b0, obi_req_o},      32'd0);
        chk("rst.rvalid", {31'b0, resp_valid_o},   32'd0);
        chk("rst.outs",   {29'b0, outstanding_o},  32'd0);
        chk("rst.pend_n", {31'b0, one_txn_pend_n}, 32'd1);
        chk("rst.busy",   {31'b0, busy_o},         32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            kill_i = vecs[i].kill; trans_valid_i = vecs[i].tv; trans_addr_i = vecs[i].ta;
            obi_gnt_i = vecs[i].gnt; obi_rvalid_i = vecs[i].rv; obi_rdata_i = vecs[i].rd;
            obi_err_i = vecs[i].err;
            #2;
            chk($sformatf("v%0d.ready", i),  {31'b0, trans_ready_o},  {31'b0, vecs[i].rdy});
            chk($sformatf("v%0d.req", i),    {31'b0, obi_req_o},      {31'b0, vecs[i].req});
            chk($sformatf("v%0d.addr", i),   obi_addr_o,              vecs[i].addr);
            chk($sformatf("v%0d.rvalid", i), {31'b0, resp_valid_o},   {31'b0, vecs[i].rvo});
            chk($sformatf("v%0d.outs", i),   {29'b0, outstanding_o},  {29'b0, vecs[i].outs});
            chk($sformatf("v%0d.pend_n", i), {31'b0, one_txn_pend_n}, {31'b0, vecs[i].pend_n});
            chk($sformatf("v%0d.busy", i),   {31'b0, busy_o},         {31'b0, vecs[i].busy});
            if (vecs[i].rvo) begin
                chk($sformatf("v%0d.rdata", i), resp_rdata_o,         vecs[i].rd);
                chk($sformatf("v%0d.err", i),   {31'b0, resp_err_o},  {31'b0, vecs[i].err});
            end
        end

        // asynchronous reset while one transaction is outstanding and one awaits grant
        @(negedge clk);
        idle_inputs();
        trans_valid_i = 1'b1; trans_addr_i = 32'h900; obi_gnt_i = 1'b1;
        @(negedge clk);
        trans_addr_i = 32'h904; obi_gnt_i = 1'b0;
        @(posedge clk);
        #1;
        chk("mid.outs_before", {29'b0, outstanding_o}, 32'd1);
        chk("mid.req_before",  {31'b0, obi_req_o},     32'd1);
        chk("mid.addr_before", obi_addr_o,             32'h904);
        trans_valid_i = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mid.outs",   {29'b0, outstanding_o},  32'd0);
        chk("mid.req",    {31'b0, obi_req_o},      32'd0);
        chk("mid.busy",   {31'b0, busy_o},         32'd0);
        chk("mid.pend_n", {31'b0, one_txn_pend_n}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        #2;
        chk("post.ready", {31'b0, trans_ready_o}, 32'd1);
        chk("post.busy",  {31'b0, busy_o},        32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
